fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the 8-bit byte address into the memory.
- Captures the 32-bit word returned in the same cycle into a fetch register, together with its PC.
- Hands the fetch register to decode over a valid/ready handshake; supports stall, halt and branch/jump redirect with flush.

---
 rtl/rv_fetch_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_reg.sv | 36 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants, imported by the fetch unit, its interface and decode.
package rv_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 8;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned PC_STEP      = 4;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Instruction packet handed from fetch to decode.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, control inputs and the decode handshake.
interface fetch_unit_if
  import rv_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
);

  logic              fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              fault;

  // Fetch unit side.
  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, fault
  );

  // Environment side: memory, control and decode.
  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, fault
  );

endinterface

// File: rtl/fetch_reg.sv
// Valid/ready pipeline holding register with flush; reusable between pipeline stages.
module fetch_reg #(
  parameter int unsigned Width = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             ready_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  // Flush beats load, load beats handshake drain; otherwise hold (stall keeps data stable).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// hands {instr, pc} to decode. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PktW = DATA_W + ADDR_W;

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              valid;
  logic              load;
  logic              flush;
  logic [PktW-1:0]   pkt_d;
  logic [PktW-1:0]   pkt_q;

  // Targets are word aligned; low bits are dropped (only reachable when the trap is off).
  assign redirect_tgt = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // Redirect flushes in every state but FAULT and blocks the load in its cycle.
  assign flush = bus.redirect_valid && (state_q != FAULT);
  assign load  = (state_q == RUN) && bus.fetch_en && !bus.redirect_valid &&
                 (!valid || bus.out_ready);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  logic misaligned;

  assign misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  // Control FSM and PC; FAULT is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else if (state_q != FAULT) begin
      if (misaligned) begin
        state_q <= FAULT;
        fault_q <= 1'b1;
      end else begin
        state_q <= bus.fetch_en ? RUN : IDLE;
        if (bus.redirect_valid) begin
          pc_q <= redirect_tgt;
        end else if (load) begin
          pc_q <= pc_q + ADDR_W'(PC_STEP);
        end
      end
    end
  end

  assign bus.fault = fault_q;
`else
  // Control FSM and PC; fetch_en alone moves between IDLE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= bus.fetch_en ? RUN : IDLE;
      if (bus.redirect_valid) begin
        pc_q <= redirect_tgt;
      end else if (load) begin
        pc_q <= pc_q + ADDR_W'(PC_STEP);
      end
    end
  end

  assign bus.fault = 1'b0;
`endif

  assign pkt_d = {bus.imem_rdata, pc_q};

  fetch_reg #(
    .Width(PktW)
  ) u_fetch_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .flush_i(flush),
    .ready_i(bus.out_ready),
    .data_i (pkt_d),
    .valid_o(valid),
    .data_o (pkt_q)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = pkt_q[PktW-1 -: DATA_W];
  assign bus.out_pc    = pkt_q[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch stage.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic [31:0] imem [64];

  int errors = 0;
  int checks = 0;

  // Behavioural model: running flag, next pc, holding register contents.
  bit          m_run;
  bit          m_fault;
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_opc;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  fetch_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.imem_rdata = imem[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_fault = 0;
    m_pc    = 0;
    m_valid = 0;
    m_instr = '0;
    m_opc   = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (!m_fault) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.redirect_valid && (bus.redirect_pc % 4 != 0)) begin
        m_fault = 1;
        m_valid = 0;
        return;
      end
`endif
      if (bus.redirect_valid) begin
        m_pc    = int'(bus.redirect_pc) / 4 * 4;
        m_valid = 0;
      end else if (m_run && bus.fetch_en && (!m_valid || bus.out_ready)) begin
        m_instr = imem[m_pc / 4];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 4) % 256;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
      m_run = bus.fetch_en;
    end
  endtask

  // Advance one cycle, then compare every output against the model on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    if (m_valid) begin
      chk("out_instr", bus.out_instr, m_instr);
      chk("out_pc", 32'(bus.out_pc), 32'(m_opc));
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'h0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'h00100093;
    imem[1] = 32'h0ff00103;
    imem[5] = 32'h0000_0000;
    model_reset();
    rst_n              = 1'b1;
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    #1 rst_n = 1'b0;
    #2 check_reset_vals();
    cycle();
    cycle();
    rst_n = 1'b1;

    // Boot: first word the cycle after entering RUN.
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    chk("boot_idle_valid", 32'(bus.out_valid), 32'h0);
    cycle();
    chk("boot_instr0", bus.out_instr, 32'h00100093);
    chk("boot_pc0", 32'(bus.out_pc), 32'h00);
    chk("boot_addr0", 32'(bus.imem_addr), 32'h04);
    cycle();
    chk("boot_instr1", bus.out_instr, 32'h0ff00103);
    chk("boot_pc1", 32'(bus.out_pc), 32'h04);
    cycle();
    chk("pre_stall_pc", 32'(bus.out_pc), 32'h08);

    // Stall for three cycles at pc 0x08.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", 32'(bus.out_pc), 32'h08);
      chk("stall_addr", 32'(bus.imem_addr), 32'h0C);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("release_pc", 32'(bus.out_pc), 32'h0C);

    // Redirect while stalled flushes and retargets.
    bus.out_ready = 1'b0;
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h20;
    cycle();
    chk("redir_flush", 32'(bus.out_valid), 32'h0);
    chk("redir_addr", 32'(bus.imem_addr), 32'h20);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    cycle();
    chk("redir_first_pc", 32'(bus.out_pc), 32'h20);
    chk("redir_first_valid", 32'(bus.out_valid), 32'h1);

    // PC wraps modulo 256.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFC;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    chk("wrap_pc_fc", 32'(bus.out_pc), 32'hFC);
    cycle();
    chk("wrap_pc_00", 32'(bus.out_pc), 32'h00);

    // Halt drains the register and freezes pc; resume continues from it.
    bus.fetch_en = 1'b0;
    cycle();
    chk("halt_drain", 32'(bus.out_valid), 32'h0);
    cycle();
    cycle();
    chk("halt_frozen", 32'(bus.imem_addr), 32'h04);
    bus.fetch_en = 1'b1;
    cycle();
    cycle();
    chk("resume_pc", 32'(bus.out_pc), 32'h04);

    // Randomized traffic, aligned redirects only (misaligned ones are directed below).
    for (int i = 0; i < 400; i++) begin
      bus.fetch_en       = ($urandom_range(0, 7) != 0);
      bus.out_ready      = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = 8'($urandom) & 8'hFC;
      cycle();
    end

    // Reset mid-stall with a redirect pending: everything returns to reset values at once.
    bus.fetch_en       = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    cycle();
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_vals();
    cycle();
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    cycle();
    cycle();

    // Misaligned redirect.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h22;
    cycle();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", 32'(bus.fault), 32'h1);
    chk("mis_flush", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.redirect_valid = (i == 1);
      bus.redirect_pc    = 8'h40;
      cycle();
      chk("mis_stuck_valid", 32'(bus.out_valid), 32'h0);
    end
`else
    chk("mis_align_addr", 32'(bus.imem_addr), 32'h20);
    cycle();
    chk("mis_align_pc", 32'(bus.out_pc), 32'h20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
